// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter that shares one 3-to-8 decoder among 8 requesters.
// A winner keeps the grant until it releases its request, the arbiter is
// disabled, or it has held the grant for MAX_HOLD cycles.
// Between two grants there is always one cycle with the decoder disabled,
// so the decoder never switches outputs while it is enabled.
// The decoder select and enable come straight from flops. The one-hot
// grant is decoded from those flops for requesters that do not decode.
module dec_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic       sel_en,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // The grant ends when the hold counter shows this value and the
  // requester still wants the decoder.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       ptr;
  logic [2:0]       ptr_nxt;
  logic [2:0]       sel_nxt;
  logic             sel_en_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_nxt;
  logic             preempt_nxt;

  logic             rel;
  logic             en_drop;
  logic             tmo;

  // Return the first set request found by scanning p, p+1, ..., p+7
  // (mod 8). The loop runs from the far end toward p, so the nearest hit
  // is the last one assigned. The result is only used when r is nonzero.
  function automatic logic [2:0] rr_pick(input logic [7:0] r,
                                         input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] pick;
    pick = p;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Exit causes for the current grant. The checks run in this order:
  // release, then disable, then timeout.
  always_comb begin
    rel     = ~req[sel];
    en_drop = ~en;
    tmo     = (hold_cnt == HOLD_LAST);
  end

  // State and registered decoder controls. Reset clears them at once, so
  // the decoder is released without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      sel      <= 3'd0;
      sel_en   <= 1'b0;
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      sel      <= sel_nxt;
      sel_en   <= sel_en_nxt;
      hold_cnt <= hold_cnt_nxt;
      preempt  <= preempt_nxt;
    end
  end

  // Next-state logic. sel only loads when a new grant starts, and it holds
  // its last value through IDLE.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    sel_nxt      = sel;
    sel_en_nxt   = sel_en;
    hold_cnt_nxt = hold_cnt;
    preempt_nxt  = 1'b0;
    case (state)
      IDLE: begin
        sel_en_nxt   = 1'b0;
        hold_cnt_nxt = '0;
        if (en && (req != 8'd0)) begin
          state_nxt    = GRANT;
          sel_nxt      = rr_pick(req, ptr);
          sel_en_nxt   = 1'b1;
          hold_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (rel || en_drop || tmo) begin
          // The requester that was just served becomes the lowest priority
          // for the next arbitration. The 3-bit add wraps 7 to 0.
          state_nxt    = IDLE;
          sel_en_nxt   = 1'b0;
          ptr_nxt      = sel + 3'd1;
          hold_cnt_nxt = '0;
          preempt_nxt  = tmo && !rel && !en_drop;
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Decode the registered select and enable into a one-hot grant.
  always_comb begin
    gnt = 8'd0;
    if (sel_en) gnt[sel] = 1'b1;
    busy = sel_en;
  end

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Bench for dec_rr_arbiter. Two instances share the same stimulus: one with
// a short hold limit (2) and one with the default limit (16). Each instance
// is checked every cycle against a reference model of arbitration rounds.
// In the model, an owner holds the decoder for a counted number of cycles.
module tb_dec_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;

  logic [2:0] sel_a,  sel_b;
  logic       sel_en_a, sel_en_b;
  logic [7:0] gnt_a,  gnt_b;
  logic       busy_a, busy_b;
  logic       preempt_a, preempt_b;

  always #5 clk = ~clk;

  dec_rr_arbiter #(.MAX_HOLD(2), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .sel(sel_a), .sel_en(sel_en_a), .gnt(gnt_a), .busy(busy_a),
    .preempt(preempt_a)
  );

  dec_rr_arbiter #(.MAX_HOLD(16), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .sel(sel_b), .sel_en(sel_en_b), .gnt(gnt_b), .busy(busy_b),
    .preempt(preempt_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model, one entry per instance.
  // owner = -1 means nobody holds the decoder.
  int m_owner[2];
  int m_held[2];
  int m_ptr[2];
  int m_sel[2];
  bit m_pre[2];
  int m_max[2] = '{2, 16};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_held[d]  = 0;
      m_ptr[d]   = 0;
      m_sel[d]   = 0;
      m_pre[d]   = 1'b0;
    end
  endtask

  // Advance both models by one clock edge, using the inputs seen at that edge.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      m_pre[d] = 1'b0;
      if (m_owner[d] >= 0) begin
        if (!req[m_owner[d]] || !en) begin
          m_ptr[d]   = (m_owner[d] + 1) % 8;
          m_owner[d] = -1;
        end else if (m_held[d] >= m_max[d]) begin
          m_ptr[d]   = (m_owner[d] + 1) % 8;
          m_owner[d] = -1;
          m_pre[d]   = 1'b1;
        end else begin
          m_held[d]++;
        end
      end else if (en && req != 8'd0) begin
        for (int k = 7; k >= 0; k--) begin
          if (req[(m_ptr[d] + k) % 8]) m_owner[d] = (m_ptr[d] + k) % 8;
        end
        m_sel[d]  = m_owner[d];
        m_held[d] = 1;
      end
    end
  endtask

  task automatic check_model();
    logic [7:0] eg;
    for (int d = 0; d < 2; d++) begin
      string n;
      n  = (d == 0) ? "A" : "B";
      eg = (m_owner[d] >= 0) ? 8'(1 << m_owner[d]) : 8'd0;
      chk({n, ".sel"},     {5'd0, (d == 0) ? sel_a : sel_b},   8'(m_sel[d]));
      chk({n, ".sel_en"},  {7'd0, (d == 0) ? sel_en_a : sel_en_b}, {7'd0, m_owner[d] >= 0});
      chk({n, ".gnt"},     (d == 0) ? gnt_a : gnt_b,          eg);
      chk({n, ".busy"},    {7'd0, (d == 0) ? busy_a : busy_b}, {7'd0, m_owner[d] >= 0});
      chk({n, ".preempt"}, {7'd0, (d == 0) ? preempt_a : preempt_b}, {7'd0, m_pre[d]});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_model();
  endtask

  // Assert reset just after an edge, check it, then release it one edge later.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    @(posedge clk);
    #1;
    check_model();
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    int n;
    logic prev_en;

    // Reset with everything requesting.
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'hFF;
    model_reset();
    #1;
    check_model();
    repeat (2) cycle();
    chk("rst.sel",    {5'd0, sel_b}, 8'h00);
    chk("rst.sel_en", {7'd0, sel_en_b}, 8'h00);
    chk("rst.gnt",    gnt_b, 8'h00);
    rst_n = 1'b1;
    cycle();
    chk("rst.first_sel", {5'd0, sel_b}, 8'h00);
    chk("rst.first_gnt", gnt_b, 8'h01);
    // Reset in the middle of a grant drops it without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.async_gnt_a", gnt_a, 8'h00);
    chk("rst.async_gnt_b", gnt_b, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    check_model();

    // Rotation: all requesting. The short-hold instance must visit 0..7 in order and then wrap.
    rst_n   = 1'b1;
    req     = 8'hFF;
    k       = 0;
    prev_en = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (sel_en_a && !prev_en) begin
        chk("rot.order", {5'd0, sel_a}, 8'(k % 8));
        k++;
      end
      prev_en = sel_en_a;
    end
    chk("rot.count", {7'd0, k >= 10}, 8'h01);

    // Release and skip.
    do_reset();
    req = 8'b0010_0100;
    cycle();
    chk("rel.sel", {5'd0, sel_b}, 8'h02);
    chk("rel.gnt", gnt_b, 8'h04);
    repeat (2) cycle();
    req = 8'b0010_0000;
    cycle();
    chk("rel.gap",     {7'd0, sel_en_b}, 8'h00);
    chk("rel.preempt", {7'd0, preempt_b}, 8'h00);
    cycle();
    chk("rel.next_sel", {5'd0, sel_b}, 8'h05);
    chk("rel.next_gnt", gnt_b, 8'h20);

    // Timeout with a single requester that never lets go.
    do_reset();
    req = 8'h40;
    n = 0;
    cycle();
    while (gnt_b == 8'h40 && n < 40) begin
      n++;
      cycle();
    end
    chk("to.len",     8'(n), 8'd16);
    chk("to.preempt", {7'd0, preempt_b}, 8'h01);
    chk("to.gap",     {7'd0, sel_en_b}, 8'h00);
    cycle();
    chk("to.regrant", gnt_b, 8'h40);

    // Enable dropped during a grant.
    do_reset();
    req = 8'h08;
    cycle();
    chk("en.sel3", {5'd0, sel_b}, 8'h03);
    en  = 1'b0;
    req = 8'hFF;
    cycle();
    chk("en.drop",    {7'd0, sel_en_b}, 8'h00);
    chk("en.preempt", {7'd0, preempt_b}, 8'h00);
    repeat (3) begin
      cycle();
      chk("en.blocked", gnt_b, 8'h00);
    end
    en = 1'b1;
    cycle();
    chk("en.sel4", {5'd0, sel_b}, 8'h04);
    chk("en.gnt4", gnt_b, 8'h10);

    // The release arrives in the same cycle the hold limit is reached (short-hold instance).
    do_reset();
    req = 8'h02;
    cycle();
    cycle();
    req = 8'h00;
    cycle();
    chk("co.sel_en",  {7'd0, sel_en_a}, 8'h00);
    chk("co.preempt", {7'd0, preempt_a}, 8'h00);
    req = 8'hFF;
    cycle();
    chk("co.next", {5'd0, sel_a}, 8'h02);

    // Randomized traffic with sparse and dense request patterns and occasional resets.
    for (int c = 0; c < 800; c++) begin
      case ($urandom_range(0, 3))
        0: req = 8'($urandom);
        1: req = 8'($urandom) & 8'($urandom);
        2: req = 8'($urandom) | 8'($urandom);
        default: ;
      endcase
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_rr_arbiter.md
Name: dec_rr_arbiter

Overview:
- Round-robin arbiter sharing one 3-to-8 decoded resource (select lines D[0:7] plus enable) among 8 requesters.
- Picks one requester and holds its grant until the requester releases or a hold limit expires.
- Drives the decoder select index and enable from registers.
- Also outputs the decoded one-hot grant for requesters that do not decode themselves.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one requester may hold the grant. Legal range is 1 to 2^CNT_W.
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  arbiter enable. Low blocks new grants and forces release of the current grant.
- req  input  8  request vector. Bit i is requester i. Level-sensitive.
- sel  output  3  registered grant index, drives the decoder A input
- sel_en  output  1  registered grant valid, drives the decoder En input
- gnt  output  8  one-hot grant. gnt[i]=1 iff sel_en=1 and sel=i. Otherwise 0. Decoded from registered sel and sel_en.
- busy  output  1  equals sel_en
- preempt  output  1  one-cycle pulse when a grant is revoked by hold timeout

Behaviour:
- Clock and reset:
  - One clock domain.
  - rst_n low asynchronously forces: state=IDLE, ptr=0, sel=0, sel_en=0, gnt=0, hold_cnt=0, preempt=0.
  - Reset mid-grant drops the grant immediately, not waiting for a clock edge.
- States: IDLE and GRANT.
- IDLE:
  - sel_en=0.
  - If en=1 and req!=0, the next edge loads sel with the first set bit scanning ptr, ptr+1, ..., ptr+7 (mod 8). It also sets sel_en=1, hold_cnt=0, state=GRANT.
  - Latency from req rising in IDLE to sel_en=1 is 1 cycle.
  - If en=0 or req=0, remain in IDLE with no change.
- GRANT:
  - hold_cnt increments each cycle.
  - Exit to IDLE on the next edge when any of these is true:
    - (a) req[sel]=0 (release)
    - (b) en=0
    - (c) hold_cnt==MAX_HOLD-1 with req[sel] still 1 (timeout)
  - On exit: sel_en=0, ptr=sel+1 mod 8 (3-bit wrap, so 7 goes to 0), and sel keeps its last value.
  - preempt=1 for exactly the exit cycle, only for case (c) when (a) and (b) are false. Otherwise preempt=0.
  - Priority when exit conditions coincide: release, then en low, then timeout.
- Turnaround:
  - Every exit passes through exactly one IDLE cycle with sel_en=0 before the next grant.
  - This holds even with continuous requests, so the decoder never switches outputs while enabled.
- Request changes:
  - Requests from other bits during GRANT are ignored until IDLE.
  - A requester dropping and re-raising req while not granted just waits its turn.
- Fairness:
  - The granted requester becomes lowest priority for the next arbitration.
  - With all 8 requesting continuously, grant order is 0,1,...,7,0,...
- MAX_HOLD=1: each grant lasts exactly 1 cycle, and a timeout with req still high pulses preempt.
- sel_en is never 1 in two grants without an intervening 0 cycle. sel changes only on an edge where sel_en goes 0 to 1.

Test Plan:
- Reset: hold rst_n=0 with req=8'hFF and en=1, then release.
  - Before release: sel=0, sel_en=0, gnt=0.
  - Next edge: sel=0, gnt=8'h01.
  - Asserting rst_n=0 mid-grant drops gnt to 0 immediately.
- Rotation: req=8'hFF held, en=1, MAX_HOLD=2.
  - Grants go 0,1,...,7,0, each 2 cycles.
  - preempt pulses on each exit.
  - One idle cycle between grants; sel wraps 7 to 0.
- Release/skip: req=8'b0010_0100 from reset.
  - sel=2, gnt=8'h04.
  - Drop req[2] after 3 cycles: sel_en=0 for 1 cycle, then sel=5, gnt=8'h20, preempt stays 0.
- Timeout: MAX_HOLD=16, only req[6]=1 held forever.
  - gnt=8'h40 for exactly 16 cycles, then preempt=1 and 1 idle cycle.
  - Then regrant to 6, since it is the only requester.
- Enable: en drops during a grant to requester 3.
  - Next edge sel_en=0, preempt=0.
  - No new grant while en=0 even with req=8'hFF.
  - Raising en grants requester 4.
- Coincident release and timeout: req[sel] falls on the cycle hold_cnt==MAX_HOLD-1.
  - Exit occurs with preempt=0 and ptr=sel+1.
